// File: rtl/wr_job_sequencer_pkg.sv
// rtl/wr_job_sequencer_pkg.sv - shared FSM state and job descriptor types for the write-job sequencer
package wr_job_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_REPORT
  } seq_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] pattern;
    logic [31:0] number;
    logic [31:0] init;
    logic        wrap_mode;
    logic [3:0]  wrap_len;
  } job_desc_t;

  localparam int DESC_W = $bits(job_desc_t);

endpackage

// File: rtl/wr_job_fifo.sv
// rtl/wr_job_fifo.sv - synchronous descriptor FIFO with full/empty flags and flush
module wr_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 165
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/wr_job_sequencer.sv
// rtl/wr_job_sequencer.sv - queues write-job descriptors and runs them one at a time on the write engine
module wr_job_sequencer
  import wr_job_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TMO_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_addr,
  input  logic [31:0] job_pattern,
  input  logic [31:0] job_number,
  input  logic [31:0] job_init,
  input  logic        job_wrap_mode,
  input  logic [3:0]  job_wrap_len,
  output logic [63:0] target_address,
  output logic [31:0] wr_pattern,
  output logic [31:0] wr_number,
  output logic [31:0] wr_init_data,
  output logic        wrap_mode,
  output logic [3:0]  wrap_len,
  output logic        engine_start_pulse,
  input  logic        wr_done_pulse,
  input  logic        wr_error,
  input  logic        abort,
  output logic        job_done_pulse,
  output logic        job_err,
  output logic        job_tmo,
  output logic        busy,
  output logic [15:0] jobs_completed
);

  seq_state_t       state;
  seq_state_t       state_next;
  job_desc_t        push_desc;
  job_desc_t        head_desc;
  job_desc_t        cfg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_inc;
  logic             tmo_hit;
  logic             err_flag;
  logic             tmo_flag;
  logic             in_engine;
  logic [15:0]      done_cnt;

  assign push_desc = '{addr: job_addr, pattern: job_pattern, number: job_number,
                       init: job_init, wrap_mode: job_wrap_mode, wrap_len: job_wrap_len};

  // A push coincident with abort is dropped rather than surviving the flush.
  assign job_ready = rst_n && !fifo_full;
  assign push      = job_valid && job_ready && !abort;
  assign pop       = (state == ST_IDLE) && !fifo_empty && !abort;

  wr_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data (push_desc),
    .pop       (pop),
    .pop_data  (head_desc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Timeout fires on the edge where the counter would become all-ones.
  assign tmo_cnt_inc = tmo_cnt + TMO_W'(1);
  assign tmo_hit     = &tmo_cnt_inc;
  assign in_engine   = (state == ST_START) || (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next         = state;
    engine_start_pulse = 1'b0;
    job_done_pulse     = 1'b0;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_next = ST_LOAD;
      ST_LOAD:   state_next = (cfg.number != '0) ? ST_START : ST_REPORT;
      ST_START: begin
        engine_start_pulse = rst_n;
        state_next         = ST_WAIT;
      end
      ST_WAIT:   if (wr_done_pulse || tmo_hit) state_next = ST_REPORT;
      ST_REPORT: begin
        job_done_pulse = rst_n && !abort;
        state_next     = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg      <= '0;
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
      tmo_flag <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (pop) begin
        cfg      <= head_desc;
        err_flag <= 1'b0;
        tmo_flag <= 1'b0;
      end else begin
        if (in_engine && wr_error) err_flag <= 1'b1;
        if (state == ST_WAIT && !wr_done_pulse && tmo_hit) tmo_flag <= 1'b1;
      end
      if (state == ST_WAIT) tmo_cnt <= tmo_cnt_inc;
      else                  tmo_cnt <= '0;
      if (job_done_pulse) done_cnt <= done_cnt + 16'd1;
    end
  end

  assign target_address = cfg.addr;
  assign wr_pattern     = cfg.pattern;
  assign wr_number      = cfg.number;
  assign wr_init_data   = cfg.init;
  assign wrap_mode      = cfg.wrap_mode;
  assign wrap_len       = cfg.wrap_len;
  assign job_err        = job_done_pulse && err_flag;
  assign job_tmo        = job_done_pulse && tmo_flag;
  assign busy           = rst_n && (!fifo_empty || state != ST_IDLE);
  assign jobs_completed = done_cnt;

endmodule

// File: tb/tb_wr_job_sequencer.sv
// tb/tb_wr_job_sequencer.sv - self-checking bench for wr_job_sequencer with a queue-based job model
module tb_wr_job_sequencer;
  import wr_job_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic [63:0] job_addr = '0;
  logic [31:0] job_pattern = '0;
  logic [31:0] job_number = '0;
  logic [31:0] job_init = '0;
  logic        job_wrap_mode = 1'b0;
  logic [3:0]  job_wrap_len = '0;
  logic        wr_done_pulse = 1'b0;
  logic        wr_error = 1'b0;
  logic        abort = 1'b0;

  logic        job_ready, engine_start_pulse, job_done_pulse, job_err, job_tmo, busy, wrap_mode;
  logic [63:0] target_address;
  logic [31:0] wr_pattern, wr_number, wr_init_data;
  logic [3:0]  wrap_len;
  logic [15:0] jobs_completed;

  logic        t_job_ready, t_engine_start_pulse, t_job_done_pulse, t_job_err, t_job_tmo, t_busy, t_wrap_mode;
  logic [63:0] t_target_address;
  logic [31:0] t_wr_pattern, t_wr_number, t_wr_init_data;
  logic [3:0]  t_wrap_len;
  logic [15:0] t_jobs_completed;

  wr_job_sequencer #(.DEPTH(4), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_addr(job_addr), .job_pattern(job_pattern), .job_number(job_number), .job_init(job_init),
    .job_wrap_mode(job_wrap_mode), .job_wrap_len(job_wrap_len),
    .target_address(target_address), .wr_pattern(wr_pattern), .wr_number(wr_number),
    .wr_init_data(wr_init_data), .wrap_mode(wrap_mode), .wrap_len(wrap_len),
    .engine_start_pulse(engine_start_pulse), .wr_done_pulse(wr_done_pulse), .wr_error(wr_error),
    .abort(abort), .job_done_pulse(job_done_pulse), .job_err(job_err), .job_tmo(job_tmo),
    .busy(busy), .jobs_completed(jobs_completed)
  );

  wr_job_sequencer #(.DEPTH(4), .TMO_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(t_job_ready),
    .job_addr(job_addr), .job_pattern(job_pattern), .job_number(job_number), .job_init(job_init),
    .job_wrap_mode(job_wrap_mode), .job_wrap_len(job_wrap_len),
    .target_address(t_target_address), .wr_pattern(t_wr_pattern), .wr_number(t_wr_number),
    .wr_init_data(t_wr_init_data), .wrap_mode(t_wrap_mode), .wrap_len(t_wrap_len),
    .engine_start_pulse(t_engine_start_pulse), .wr_done_pulse(wr_done_pulse), .wr_error(wr_error),
    .abort(abort), .job_done_pulse(t_job_done_pulse), .job_err(t_job_err), .job_tmo(t_job_tmo),
    .busy(t_busy), .jobs_completed(t_jobs_completed)
  );

  always #5 clk = ~clk;

  typedef struct { int c; job_desc_t d; } st_ev_t;
  typedef struct { int c; logic err; logic tmo; } dn_ev_t;

  st_ev_t st_q[$], t_st_q[$];
  dn_ev_t dn_q[$], t_dn_q[$];
  st_ev_t mon_s;
  dn_ev_t mon_d;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder only; all judgement happens in the test tasks.
  always @(negedge clk) begin
    if (engine_start_pulse === 1'b1) begin
      mon_s.c = cyc;
      mon_s.d = '{addr: target_address, pattern: wr_pattern, number: wr_number,
                  init: wr_init_data, wrap_mode: wrap_mode, wrap_len: wrap_len};
      st_q.push_back(mon_s);
    end
    if (job_done_pulse === 1'b1) begin
      mon_d.c = cyc; mon_d.err = job_err; mon_d.tmo = job_tmo;
      dn_q.push_back(mon_d);
    end
    if (t_engine_start_pulse === 1'b1) begin
      mon_s.c = cyc;
      mon_s.d = '{addr: t_target_address, pattern: t_wr_pattern, number: t_wr_number,
                  init: t_wr_init_data, wrap_mode: t_wrap_mode, wrap_len: t_wrap_len};
      t_st_q.push_back(mon_s);
    end
    if (t_job_done_pulse === 1'b1) begin
      mon_d.c = cyc; mon_d.err = t_job_err; mon_d.tmo = t_job_tmo;
      t_dn_q.push_back(mon_d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; job_valid = 1'b0; wr_done_pulse = 1'b0; wr_error = 1'b0; abort = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    st_q.delete(); dn_q.delete(); t_st_q.delete(); t_dn_q.delete();
  endtask

  function automatic job_desc_t rand_desc(input bit nonzero);
    job_desc_t d;
    d.addr[63:32] = $urandom;
    d.addr[31:0]  = $urandom;
    d.pattern     = $urandom;
    d.number      = nonzero ? 32'($urandom_range(1, 5000)) : 32'd0;
    d.init        = $urandom;
    d.wrap_mode   = 1'($urandom_range(0, 1));
    d.wrap_len    = 4'($urandom_range(0, 15));
    return d;
  endfunction

  task automatic set_job(input job_desc_t d);
    job_addr = d.addr; job_pattern = d.pattern; job_number = d.number;
    job_init = d.init; job_wrap_mode = d.wrap_mode; job_wrap_len = d.wrap_len;
  endtask

  task automatic push_job(input job_desc_t d, output int c);
    set_job(d);
    job_valid = 1'b1;
    c = cyc;
    step();
    job_valid = 1'b0;
  endtask

  task automatic done_pulse(output int c);
    wr_done_pulse = 1'b1;
    c = cyc;
    step();
    wr_done_pulse = 1'b0;
  endtask

  // Bounded wait until the selected instance has produced more than n0 start pulses.
  task automatic wait_start(input bit use4, input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if ((use4 ? t_st_q.size() : st_q.size()) > n0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; job_valid = 1'b1; job_number = 32'd5; job_addr = 64'hdead; wr_done_pulse = 1'b1;
    step(); step();
    @(negedge clk);
    n_checks++; if (job_ready !== 1'b0) $display("FAIL reset_job_ready: got %b expected 0", job_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if ({engine_start_pulse, job_done_pulse, job_err, job_tmo} !== 4'b0)
      $display("FAIL reset_pulses: got %b expected 0000", {engine_start_pulse, job_done_pulse, job_err, job_tmo}); else n_pass++;
    n_checks++; if ({target_address, wr_pattern, wr_number, wr_init_data, wrap_mode, wrap_len} !== '0)
      $display("FAIL reset_config: got addr %h number %h expected 0", target_address, wr_number); else n_pass++;
    n_checks++; if (jobs_completed !== 16'd0) $display("FAIL reset_count: got %0d expected 0", jobs_completed); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; job_valid = 1'b0; wr_done_pulse = 1'b0;
    @(negedge clk);
    n_checks++; if (job_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", job_ready); else n_pass++;
    repeat (4) step();
    n_checks++; if (busy !== 1'b0 || st_q.size() != 0)
      $display("FAIL reset_no_push: got busy %b starts %0d expected 0 0", busy, st_q.size()); else n_pass++;
  endtask

  task automatic test_single_job();
    job_desc_t d;
    int pc, dc;
    bit ok;
    do_reset();
    d = rand_desc(1'b1); d.addr = 64'h1000; d.number = 32'd4;
    push_job(d, pc);
    wait_start(1'b0, 0, ok);
    n_checks++; if (!ok) $display("FAIL single_start: got none expected a start pulse"); else n_pass++;
    if (ok) begin
      n_checks++; if (st_q[0].c != pc + 3) $display("FAIL single_latency: got %0d expected %0d", st_q[0].c - pc, 3); else n_pass++;
      n_checks++; if (st_q[0].d !== d) $display("FAIL single_config: got %h expected %h", st_q[0].d, d); else n_pass++;
    end
    repeat (19) step();
    done_pulse(dc);
    repeat (5) step();
    n_checks++; if (st_q.size() != 1) $display("FAIL single_start_count: got %0d expected 1", st_q.size()); else n_pass++;
    n_checks++; if (dn_q.size() != 1) $display("FAIL single_done_count: got %0d expected 1", dn_q.size()); else n_pass++;
    if (dn_q.size() == 1) begin
      n_checks++; if (dn_q[0].c != dc + 1) $display("FAIL single_done_cycle: got %0d expected %0d", dn_q[0].c, dc + 1); else n_pass++;
      n_checks++; if ({dn_q[0].err, dn_q[0].tmo} !== 2'b00) $display("FAIL single_status: got %b expected 00", {dn_q[0].err, dn_q[0].tmo}); else n_pass++;
    end
    n_checks++; if (jobs_completed !== 16'd1) $display("FAIL single_count: got %0d expected 1", jobs_completed); else n_pass++;
    n_checks++; if (target_address !== 64'h1000) $display("FAIL single_config_hold: got %h expected 1000", target_address); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_zero_number();
    job_desc_t d;
    int pc;
    do_reset();
    d = rand_desc(1'b0);
    push_job(d, pc);
    repeat (8) step();
    n_checks++; if (st_q.size() != 0) $display("FAIL zero_no_start: got %0d starts expected 0", st_q.size()); else n_pass++;
    n_checks++; if (dn_q.size() != 1) $display("FAIL zero_done_count: got %0d expected 1", dn_q.size()); else n_pass++;
    if (dn_q.size() == 1) begin
      n_checks++; if (dn_q[0].c != pc + 3) $display("FAIL zero_done_cycle: got %0d expected %0d", dn_q[0].c, pc + 3); else n_pass++;
      n_checks++; if ({dn_q[0].err, dn_q[0].tmo} !== 2'b00) $display("FAIL zero_status: got %b expected 00", {dn_q[0].err, dn_q[0].tmo}); else n_pass++;
    end
    n_checks++; if (jobs_completed !== 16'd1) $display("FAIL zero_count: got %0d expected 1", jobs_completed); else n_pass++;
  endtask

  task automatic test_error();
    job_desc_t d;
    int pc, dc;
    bit ok;
    do_reset();
    d = rand_desc(1'b1);
    push_job(d, pc);
    wait_start(1'b0, 0, ok);
    step(); step();
    wr_error = 1'b1; step(); wr_error = 1'b0;
    step(); step();
    done_pulse(dc);
    repeat (3) step();
    wr_error = 1'b1; wr_done_pulse = 1'b1; step(); wr_error = 1'b0; wr_done_pulse = 1'b0;
    step(); step();
    n_checks++; if (jobs_completed !== 16'd1 || busy !== 1'b0)
      $display("FAIL err_stray_ignored: got count %0d busy %b expected 1 0", jobs_completed, busy); else n_pass++;
    d = rand_desc(1'b1);
    push_job(d, pc);
    wait_start(1'b0, 1, ok);
    n_checks++; if (!ok) $display("FAIL err_second_start: got none expected a start pulse"); else n_pass++;
    repeat (3) step();
    done_pulse(dc);
    repeat (3) step();
    n_checks++; if (dn_q.size() != 2) $display("FAIL err_done_count: got %0d expected 2", dn_q.size()); else n_pass++;
    if (dn_q.size() == 2) begin
      n_checks++; if (dn_q[0].err !== 1'b1) $display("FAIL err_first_job: got %b expected 1", dn_q[0].err); else n_pass++;
      n_checks++; if (dn_q[1].err !== 1'b0) $display("FAIL err_second_job: got %b expected 0", dn_q[1].err); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    job_desc_t exp_q[$], exp_nz[$], d;
    bit        err_exp[$];
    int        pc, dc, ns, dly;
    bit        ok, inj;
    do_reset();
    d = rand_desc(1'b1);
    exp_q.push_back(d); exp_nz.push_back(d);
    push_job(d, pc);
    wait_start(1'b0, 0, ok);
    n_checks++; if (!ok) $display("FAIL b2b_first_start: got none expected a start pulse"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      d = rand_desc($urandom_range(0, 3) != 0);
      exp_q.push_back(d);
      if (d.number != 0) exp_nz.push_back(d);
      push_job(d, pc);
    end
    n_checks++; if (job_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", job_ready); else n_pass++;
    d = rand_desc(1'b1);
    push_job(d, pc);
    ns = 0;
    for (int j = 0; j < 5; j++) begin
      if (exp_q[j].number != 0) begin
        if (j > 0) begin
          wait_start(1'b0, ns, ok);
          n_checks++; if (!ok) $display("FAIL b2b_start_wait: job %0d got no start expected one", j); else n_pass++;
        end
        ns++;
        inj = 1'($urandom_range(0, 1));
        dly = $urandom_range(1, 10);
        err_exp.push_back(inj);
        wr_error = inj; step(); wr_error = 1'b0;
        repeat (dly - 1) step();
        done_pulse(dc);
      end else begin
        err_exp.push_back(1'b0);
      end
    end
    repeat (20) step();
    n_checks++; if (st_q.size() != exp_nz.size()) $display("FAIL b2b_start_count: got %0d expected %0d", st_q.size(), exp_nz.size()); else n_pass++;
    for (int i = 0; i < exp_nz.size() && i < st_q.size(); i++) begin
      n_checks++; if (st_q[i].d !== exp_nz[i]) $display("FAIL b2b_config: start %0d got %h expected %h", i, st_q[i].d, exp_nz[i]); else n_pass++;
    end
    n_checks++; if (dn_q.size() != 5) $display("FAIL b2b_done_count: got %0d expected 5", dn_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < dn_q.size(); i++) begin
      n_checks++; if ({dn_q[i].err, dn_q[i].tmo} !== {err_exp[i], 1'b0})
        $display("FAIL b2b_status: job %0d got %b expected %b", i, {dn_q[i].err, dn_q[i].tmo}, {err_exp[i], 1'b0}); else n_pass++;
    end
    n_checks++; if (jobs_completed !== 16'd5) $display("FAIL b2b_count: got %0d expected 5", jobs_completed); else n_pass++;
  endtask

  task automatic test_timeout();
    job_desc_t d;
    int pc, dc, s, k, exp_c;
    bit ok, exp_tmo;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      d = rand_desc(1'b1);
      push_job(d, pc);
      wait_start(1'b1, j, ok);
      n_checks++; if (!ok) $display("FAIL tmo_start: job %0d got none expected a start pulse", j); else n_pass++;
      s = ok ? t_st_q[j].c : cyc;
      // Job 0 never gets done; job 1 gets done on the last WAIT cycle; the rest are random.
      k = (j == 0) ? 99 : (j == 1) ? 15 : $urandom_range(10, 20);
      if (k <= 20) begin
        repeat (k - 1) step();
        done_pulse(dc);
        repeat (5) step();
      end else begin
        repeat (25) step();
      end
      exp_tmo = (k > 15);
      exp_c   = s + 1 + (exp_tmo ? 15 : k);
      n_checks++; if (t_dn_q.size() != j + 1) $display("FAIL tmo_done_count: job %0d got %0d expected %0d", j, t_dn_q.size(), j + 1); else n_pass++;
      if (t_dn_q.size() == j + 1) begin
        n_checks++; if (t_dn_q[j].c != exp_c) $display("FAIL tmo_done_cycle: job %0d k %0d got %0d expected %0d", j, k, t_dn_q[j].c - s, exp_c - s); else n_pass++;
        n_checks++; if ({t_dn_q[j].err, t_dn_q[j].tmo} !== {1'b0, exp_tmo})
          $display("FAIL tmo_status: job %0d k %0d got %b expected %b", j, k, {t_dn_q[j].err, t_dn_q[j].tmo}, {1'b0, exp_tmo}); else n_pass++;
      end
    end
    n_checks++; if (t_jobs_completed !== 16'd5) $display("FAIL tmo_count: got %0d expected 5", t_jobs_completed); else n_pass++;
  endtask

  task automatic test_abort();
    job_desc_t d;
    int pc;
    bit ok;
    do_reset();
    push_job(rand_desc(1'b1), pc);
    wait_start(1'b0, 0, ok);
    push_job(rand_desc(1'b1), pc);
    push_job(rand_desc(1'b0), pc);
    set_job(rand_desc(1'b1));
    abort = 1'b1; job_valid = 1'b1;
    step();
    abort = 1'b0; job_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (job_done_pulse !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", job_done_pulse); else n_pass++;
    repeat (10) step();
    n_checks++; if (st_q.size() != 1 || dn_q.size() != 0)
      $display("FAIL abort_flushed: got starts %0d dones %0d expected 1 0", st_q.size(), dn_q.size()); else n_pass++;
    n_checks++; if (jobs_completed !== 16'd0) $display("FAIL abort_count: got %0d expected 0", jobs_completed); else n_pass++;

    push_job(rand_desc(1'b0), pc);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (5) step();
    n_checks++; if (dn_q.size() != 0 || jobs_completed !== 16'd0)
      $display("FAIL abort_report: got dones %0d count %0d expected 0 0", dn_q.size(), jobs_completed); else n_pass++;

    push_job(rand_desc(1'b1), pc);
    wait_start(1'b0, 1, ok);
    repeat (3) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (10) step();
    n_checks++; if (dn_q.size() != 0 || jobs_completed !== 16'd0 || busy !== 1'b0 || st_q.size() != 2)
      $display("FAIL reset_mid_job: got dones %0d count %0d busy %b starts %0d expected 0 0 0 2",
               dn_q.size(), jobs_completed, busy, st_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_zero_number();
    test_error();
    test_back_to_back();
    test_back_to_back();
    test_timeout();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wr_job_sequencer.md
WR_JOB_SEQUENCER -- requirements
Module: wr_job_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning job descriptor FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL have parameter TMO_W, default 24, meaning timeout counter width.
REQ-003 Port clk  in  1  clock.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port job_valid / job_ready  in / out  1 / 1  descriptor push handshake.
REQ-006 Port job_addr / job_pattern / job_number / job_init  in  64/32/32/32  descriptor fields.
REQ-007 Port job_wrap_mode / job_wrap_len  in  1/4  descriptor wrap fields.
REQ-008 Port target_address / wr_pattern / wr_number / wr_init_data / wrap_mode / wrap_len  out  64/32/32/32/1/4  write-engine configuration.
REQ-009 Port engine_start_pulse  out  1  engine start.
REQ-010 Port wr_done_pulse / wr_error  in  1/1  engine completion and per-response error.
REQ-011 Port abort  in  1  flush queue and abandon current job.
REQ-012 Port job_done_pulse / job_err / job_tmo  out  1/1/1  per-job completion status.
REQ-013 Port busy  out  1  FIFO non-empty or state not IDLE.
REQ-014 Port jobs_completed  out  16  completed-job count.

Function
REQ-015 Push SHALL occur when job_valid && job_ready; job_ready SHALL equal FIFO not full; push while full SHALL be impossible.
REQ-016 FSM states SHALL be IDLE, LOAD, START, WAIT, REPORT.
REQ-017 IDLE->LOAD when FIFO non-empty; LOAD pops head and registers it onto the config outputs.
REQ-018 LOAD->START if wr_number != 0; LOAD->REPORT directly if wr_number == 0, with no start pulse.
REQ-019 START SHALL assert engine_start_pulse for exactly one cycle, then go to WAIT; start-to-pulse latency from push into empty idle block = 3 cycles.
REQ-020 Config outputs SHALL stay constant from LOAD until next LOAD.
REQ-021 In START and WAIT, any wr_error cycle SHALL set a sticky job error flag, cleared at LOAD.
REQ-022 WAIT->REPORT on wr_done_pulse; WAIT timeout counter starts at 0 on entry and increments per cycle.
REQ-023 On counter reaching all-ones, WAIT->REPORT with timeout flag set.
REQ-024 wr_done_pulse coincident with timeout SHALL be treated as done, no timeout.
REQ-025 REPORT SHALL pulse job_done_pulse one cycle with job_err/job_tmo valid that cycle (else 0), increment jobs_completed (wraps 0xFFFF->0), then go to IDLE.
REQ-026 Push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-027 abort SHALL empty FIFO and force IDLE next cycle with no job_done_pulse; abort during REPORT SHALL suppress the pulse; a push coincident with abort SHALL be dropped.
REQ-028 wr_done_pulse or wr_error outside START/WAIT SHALL be ignored.

Reset
REQ-029 On rst_n low: state IDLE, FIFO empty, all config outputs 0, engine_start_pulse/job_done_pulse/job_err/job_tmo 0, jobs_completed 0, busy 0, job_ready 0 during reset and 1 the cycle after.
REQ-030 Reset mid-job SHALL abandon it with no completion pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the descriptor record (addr, pattern, number, init, wrap_mode, wrap_len = 165 bits).
REQ-032 One sub-module, wr_job_fifo (synchronous FIFO, DEPTH x 165, full/empty flags), SHALL hold the queue.

Verification
REQ-033 Single job addr 0x1000, number 4; done after 20 cycles -> one start pulse, one job_done_pulse, job_err=0, jobs_completed=1.
REQ-034 Four jobs pushed back-to-back, DEPTH=4 -> job_ready low after fourth push while the first is not yet popped, four starts in order, config matches each descriptor.
REQ-035 Job number 0 -> no engine_start_pulse, job_done_pulse 2 cycles after pop, err=0, tmo=0.
REQ-036 wr_error pulse mid-WAIT then done -> job_err=1 for that job; next job job_err=0.
REQ-037 TMO_W=4, no done -> job_tmo=1 after 15 WAIT cycles; done on that same cycle -> job_tmo=0.
REQ-038 abort with 2 jobs queued during WAIT -> IDLE next cycle, busy=0, no job_done_pulse, jobs_completed unchanged.
